q2_sequencer: RTL

// - Generates the Q2 CPU state bits s0..s3 and write strobe ws consumed by q2_control.
// - Walks FETCH -> [DEREF] -> [LOAD] -> EXEC -> [ALU x ALU_STEPS] -> FETCH.
// - Optional states are skipped by opcode bits.
// - Run/stop/single-step front-panel control: the CPU halts only at an instruction boundary.

---
 rtl/q2_sequencer_pkg.sv | 27 ++
 rtl/q2_sequencer_if.sv | 26 ++
 rtl/q2_edge_detect.sv | 20 ++
 rtl/q2_sequencer.sv | 109 ++++++++++
 4 files changed

// File: rtl/q2_sequencer_pkg.sv
// Shared definitions for the Q2 CPU sequencer: state codes, phase type and
// small helpers used by the sequencer and by anything decoding its state bits.
package q2_sequencer_pkg;

  localparam logic [3:0] Q2_S_FETCH = 4'h0;
  localparam logic [3:0] Q2_S_DEREF = 4'h1;
  localparam logic [3:0] Q2_S_LOAD  = 4'h2;
  localparam logic [3:0] Q2_S_EXEC  = 4'h3;
  localparam logic [3:0] Q2_S_ALU0  = 4'h4;

  // Every state is split into a settle half and a write-strobe half.
  typedef enum logic {
    PH_SETTLE = 1'b0,
    PH_STROBE = 1'b1
  } q2_phase_e;

  // Code of the last bit-serial ALU state; anything above it is unreachable.
  function automatic logic [3:0] q2_alu_max(input int unsigned steps);
    return 4'(steps + 32'd3);
  endfunction

  // Opcodes that need the bit-serial ALU pass after EXEC.
  function automatic logic q2_is_alu_op(input logic op3, input logic op4, input logic op5);
    return ~op5 | (~op3 & ~op4);
  endfunction

endpackage

// File: rtl/q2_sequencer_if.sv
// Front-panel controls, opcode bits and state outputs of the Q2 sequencer.
// master drives the panel/opcode side, slave is the sequencer itself.
interface q2_sequencer_if;
  logic run_sw;
  logic step_sw;
  logic op2;
  logic op3;
  logic op4;
  logic op5;
  logic s0;
  logic s1;
  logic s2;
  logic s3;
  logic ws;
  logic running;

  modport master (
    output run_sw, step_sw, op2, op3, op4, op5,
    input  s0, s1, s2, s3, ws, running
  );

  modport slave (
    input  run_sw, step_sw, op2, op3, op4, op5,
    output s0, s1, s2, s3, ws, running
  );
endinterface

// File: rtl/q2_edge_detect.sv
// Rising-edge detector for the step switch: one registered copy of the
// input, rise is high for the single clock where d is 1 and was 0 before.
module q2_edge_detect (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o
);

  logic prev_q;

  // Remember last cycle's level.
  always_ff @(posedge clk_i) begin
    if (rst_i) prev_q <= 1'b0;
    else       prev_q <= d_i;
  end

  assign rise_o = d_i & ~prev_q;

endmodule

// File: rtl/q2_sequencer.sv
// Q2 CPU state sequencer: generates state bits s0..s3 and write strobe ws,
// and implements run / stop / single-step control at instruction boundaries.
//
//   state       | meaning
//   ------------+------------------------------------------------------
//   0000 FETCH  | fetch instruction; halt decision taken in phase 0
//   0001 DEREF  | indirect address dereference (op2=1)
//   0010 LOAD   | memory operand load (op5=0)
//   0011 EXEC   | execute
//   0100..ALU_MAX | bit-serial ALU shift steps (alu_op only)
//   above ALU_MAX | unreachable; recovers to FETCH phase 0
//
//   Each state has phase 0 (settle, ws=0) then phase 1 (ws=1); the state
//   code changes on the edge that ends phase 1.
module q2_sequencer
  import q2_sequencer_pkg::*;
#(
  parameter int unsigned ALU_STEPS = 8
) (
  input logic             clk_i,
  input logic             rst_i,
  q2_sequencer_if.slave   bus
);

  localparam logic [3:0] ALU_MAX = q2_alu_max(ALU_STEPS);

  logic [3:0] state_q, state_d;
  q2_phase_e  phase_q, phase_d;
  logic       running_q, running_d;
  logic       step_pending_q, step_pending_d;
  logic       step_rise;
  logic       alu_op;

  q2_edge_detect u_step_edge (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .d_i    (bus.step_sw),
    .rise_o (step_rise)
  );

  assign alu_op = q2_is_alu_op(bus.op3, bus.op4, bus.op5);

  // State, phase, run status and pending-step registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q        <= Q2_S_FETCH;
      phase_q        <= PH_SETTLE;
      running_q      <= 1'b0;
      step_pending_q <= 1'b0;
    end else begin
      state_q        <= state_d;
      phase_q        <= phase_d;
      running_q      <= running_d;
      step_pending_q <= step_pending_d;
    end
  end

  // Next-state: phase toggling, instruction-boundary halt and state walk.
  always_comb begin
    state_d        = state_q;
    phase_d        = phase_q;
    running_d      = running_q;
    step_pending_d = step_pending_q;

    // Steps only count while halted; a step during an instruction is dropped.
    if (step_rise && !running_q) step_pending_d = 1'b1;

    if (state_q > ALU_MAX) begin
      state_d   = Q2_S_FETCH;
      phase_d   = PH_SETTLE;
      running_d = bus.run_sw;
    end else if (phase_q == PH_SETTLE) begin
      if (state_q == Q2_S_FETCH) begin
        if (bus.run_sw || step_pending_q) begin
          phase_d        = PH_STROBE;
          running_d      = 1'b1;
          step_pending_d = 1'b0;
        end else begin
          running_d = 1'b0;
        end
      end else begin
        phase_d = PH_STROBE;
      end
    end else begin
      phase_d = PH_SETTLE;
      case (state_q)
        Q2_S_FETCH: begin
          if (bus.op2)       state_d = Q2_S_DEREF;
          else if (!bus.op5) state_d = Q2_S_LOAD;
          else               state_d = Q2_S_EXEC;
        end
        Q2_S_DEREF: state_d = bus.op5 ? Q2_S_EXEC : Q2_S_LOAD;
        Q2_S_LOAD:  state_d = Q2_S_EXEC;
        Q2_S_EXEC:  state_d = alu_op ? Q2_S_ALU0 : Q2_S_FETCH;
        default:    state_d = (state_q == ALU_MAX) ? Q2_S_FETCH : state_q + 4'd1;
      endcase
      // Entering FETCH ends the instruction; keep running only if free-running.
      if (state_d == Q2_S_FETCH) running_d = bus.run_sw;
    end
  end

  assign bus.s0      = state_q[0];
  assign bus.s1      = state_q[1];
  assign bus.s2      = state_q[2];
  assign bus.s3      = state_q[3];
  assign bus.ws      = (phase_q == PH_STROBE);
  assign bus.running = running_q;

endmodule
